// File: rtl/mem_pkg.sv
// ---------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the MEM-stage SRAM controller.
//   mem_state_e         : controller FSM states (IDLE, LO, HI, DONE)
//   ADDR_OFFSET_DEFAULT : CPU byte address where the data-memory region starts
//   SRAM_DATA_W         : width of the external SRAM data bus
//   sram_half_addr()    : CPU byte address + half select -> SRAM half-word addr
// ---------------------------------------------------------------------------
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } mem_state_e;

    localparam int ADDR_OFFSET_DEFAULT = 1024;
    localparam int SRAM_DATA_W         = 16;

    // Each 32-bit word occupies two consecutive SRAM half-words; the low
    // half sits at the even address. Addresses below the offset simply wrap,
    // the caller truncates the result to the SRAM address width.
    function automatic logic [31:0] sram_half_addr(
        input logic [31:0] byte_addr,
        input logic [31:0] offset,
        input logic        half
    );
        logic [31:0] word_idx;
        word_idx = (byte_addr - offset) >> 2;
        return {word_idx[30:0], half};
    endfunction

endpackage

// File: rtl/mem_stage_sram_ctrl.sv
// ---------------------------------------------------------------------------
// mem_stage_sram_ctrl
// MEM-stage controller: turns one 32-bit load/store into two 16-bit accesses
// on an asynchronous SRAM (low half first), each phase held WAIT_CYCLES+1
// cycles. ready freezes the pipeline while an access is in flight.
//
// Ports
//   clk, rst     : clock, asynchronous active-high reset
//   rd_en, wr_en : load / store request (both high = store)
//   address      : word-aligned CPU byte address
//   write_data   : store data
//   read_data    : load result, valid when ready=1 after a load
//   ready        : 1 = pipeline may advance, 0 = freeze
//   sram_addr    : SRAM half-word address
//   sram_dq_out  : data driven onto SRAM DQ
//   sram_dq_in   : data returned by SRAM DQ
//   sram_dq_oe   : 1 = controller drives DQ
//   sram_we_n    : SRAM write strobe, active-low
//
// Handshake: a request is accepted on the rising edge where the FSM is IDLE
// and rd_en|wr_en is high; ready is low from that cycle until the single
// DONE cycle, in which the pipeline advances. Inputs seen while busy are
// ignored, so a flushed request never leaves a store half-written.
// ---------------------------------------------------------------------------
module mem_stage_sram_ctrl
    import mem_pkg::*;
#(
    parameter int ADDR_OFFSET = ADDR_OFFSET_DEFAULT,
    parameter int SRAM_ADDR_W = 18,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rd_en,
    input  logic                   wr_en,
    input  logic [31:0]            address,
    input  logic [31:0]            write_data,
    output logic [31:0]            read_data,
    output logic                   ready,
    output logic [SRAM_ADDR_W-1:0] sram_addr,
    output logic [SRAM_DATA_W-1:0] sram_dq_out,
    input  logic [SRAM_DATA_W-1:0] sram_dq_in,
    output logic                   sram_dq_oe,
    output logic                   sram_we_n
);

    localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES);

    mem_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             op_write_q;
    logic [31:0]      addr_q;
    logic [31:0]      data_q;
    logic             req;
    logic             in_phase;
    logic             phase_last;
    logic [SRAM_ADDR_W-1:0] phase_addr;

    assign req        = rd_en | wr_en;
    assign in_phase   = (state_q == LO) || (state_q == HI);
    assign phase_last = in_phase && (cnt_q == CNT_LAST);
    assign phase_addr = SRAM_ADDR_W'(sram_half_addr(addr_q, 32'(ADDR_OFFSET),
                                                    state_q == HI));

    // FSM state and phase counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = LO;
                    cnt_d   = '0;
                end
            end
            LO, HI: begin
                if (phase_last) begin
                    cnt_d   = '0;
                    state_d = (state_q == LO) ? HI : DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Request capture; wr_en wins when both enables are high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_write_q <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
        end else if (state_q == IDLE && req) begin
            op_write_q <= wr_en;
            addr_q     <= address;
            data_q     <= write_data;
        end
    end

    // Load data is sampled at the end of each phase, after the SRAM has had
    // the full wait time to settle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            read_data <= '0;
        end else if (!op_write_q && phase_last) begin
            if (state_q == LO) begin
                read_data[15:0] <= sram_dq_in;
            end else begin
                read_data[31:16] <= sram_dq_in;
            end
        end
    end

    // SRAM bus and ready are decoded from state so that an asynchronous
    // reset releases the write strobe and the DQ bus in the same instant.
    always_comb begin
        sram_addr   = '0;
        sram_dq_out = '0;
        sram_dq_oe  = 1'b0;
        sram_we_n   = 1'b1;
        ready       = 1'b0;
        if (in_phase) begin
            sram_addr = phase_addr;
            if (op_write_q) begin
                sram_dq_oe  = 1'b1;
                sram_we_n   = 1'b0;
                sram_dq_out = (state_q == HI) ? data_q[31:16] : data_q[15:0];
            end
        end
        if ((state_q == IDLE && !req) || state_q == DONE) begin
            ready = 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mem_stage_sram_ctrl
// Drives random loads/stores into the controller, keeps a word-level memory
// model, and checks latency and read_data on every completion.
// ---------------------------------------------------------------------------
module tb_mem_stage_sram_ctrl;

    localparam int W   = 2;
    localparam int AW  = 18;
    localparam int OFF = 1024;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT (default wait states) ----------------
    logic          rd_en, wr_en;
    logic [31:0]   address, write_data, read_data;
    logic          ready;
    logic [AW-1:0] sram_addr;
    logic [15:0]   sram_dq_out, sram_dq_in;
    logic          sram_dq_oe, sram_we_n;

    mem_stage_sram_ctrl #(.ADDR_OFFSET(OFF), .SRAM_ADDR_W(AW), .WAIT_CYCLES(W)) dut (
        .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en),
        .address(address), .write_data(write_data), .read_data(read_data),
        .ready(ready), .sram_addr(sram_addr), .sram_dq_out(sram_dq_out),
        .sram_dq_in(sram_dq_in), .sram_dq_oe(sram_dq_oe), .sram_we_n(sram_we_n)
    );

    // ---------------- DUT (zero wait states) ----------------
    logic          rd_en_z, wr_en_z;
    logic [31:0]   address_z, write_data_z, read_data_z;
    logic          ready_z;
    logic [AW-1:0] sram_addr_z;
    logic [15:0]   sram_dq_out_z, sram_dq_in_z;
    logic          sram_dq_oe_z, sram_we_n_z;
    logic [15:0]   z_lo, z_hi;

    mem_stage_sram_ctrl #(.ADDR_OFFSET(OFF), .SRAM_ADDR_W(AW), .WAIT_CYCLES(0)) dut_z (
        .clk(clk), .rst(rst), .rd_en(rd_en_z), .wr_en(wr_en_z),
        .address(address_z), .write_data(write_data_z), .read_data(read_data_z),
        .ready(ready_z), .sram_addr(sram_addr_z), .sram_dq_out(sram_dq_out_z),
        .sram_dq_in(sram_dq_in_z), .sram_dq_oe(sram_dq_oe_z), .sram_we_n(sram_we_n_z)
    );

    assign sram_dq_in_z = (sram_addr_z == '0) ? z_lo :
                          (sram_addr_z == AW'(1)) ? z_hi : 16'h0000;

    // ---------------- SRAM model with preload port ----------------
    logic [15:0]   sram_mem [0:(1<<AW)-1];
    logic          pl_en = 1'b0;
    logic [AW-1:0] pl_hw = '0;
    logic [31:0]   pl_word = '0;

    assign sram_dq_in = sram_mem[sram_addr];

    always @(posedge clk) begin
        if (pl_en) begin
            sram_mem[pl_hw]         <= pl_word[15:0];
            sram_mem[pl_hw + 1'b1]  <= pl_word[31:16];
        end else if (!sram_we_n && sram_dq_oe) begin
            sram_mem[sram_addr] <= sram_dq_out;
        end
    end

    // ---------------- reference model and scoreboard ----------------
    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] model_rd = 32'h0;
    logic [39:0] exp_q[$];       // {expected low cycles, expected read_data}
    int n_cmp  = 0;
    int n_fail = 0;
    bit just_done = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // monitor: counts ready-low cycles, compares on each completion
    int low_cnt = 0;
    always @(posedge clk) begin
        logic [39:0] e;
        #1;
        if (rst) begin
            low_cnt = 0;
        end else if (!ready) begin
            low_cnt++;
        end else if (low_cnt > 0) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_completion: got low=%0d expected none", low_cnt);
            end else begin
                e = exp_q.pop_front();
                check("latency", 32'(low_cnt), 32'(e[39:32]));
                check("read_data", read_data, e[31:0]);
            end
            low_cnt = 0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic preload(input logic [31:0] addr, input logic [31:0] word);
        logic [31:0] diff;
        int unsigned widx, hw;
        diff = addr - 32'(OFF);
        widx = diff / 4;
        hw   = (widx * 2) % (1 << AW);
        @(negedge clk);
        pl_en   = 1'b1;
        pl_hw   = AW'(hw);
        pl_word = word;
        @(negedge clk);
        pl_en = 1'b0;
        ref_mem[addr] = word;
    endtask

    task automatic drop();
        @(negedge clk);
        rd_en = 1'b0;
        wr_en = 1'b0;
    endtask

    task automatic issue(input logic w, input logic r, input logic [31:0] a,
                         input logic [31:0] d, input bit gap);
        int lows;
        bit seen;
        if (gap) begin
            drop();
            just_done = 1'b0;
        end
        lows = 2 * (W + 1) + (just_done ? 1 : 0);
        @(negedge clk);
        wr_en = w; rd_en = r; address = a; write_data = d;
        if (w) ref_mem[a] = d;
        else model_rd = ref_mem.exists(a) ? ref_mem[a] : 32'h0;
        exp_q.push_back({8'(lows), model_rd});
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge clk);
            #1;
            if (ready) seen = 1'b1;
        end
        if (!seen) begin
            n_cmp++;
            n_fail++;
            $display("FAIL timeout: ready never rose for addr %h", a);
        end
        just_done = 1'b1;
    endtask

    task automatic idle_check(input int n);
        drop();
        just_done = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
            check("idle_ready", 32'(ready), 32'd1);
            check("idle_we_n", 32'(sram_we_n), 32'd1);
            check("idle_oe", 32'(sram_dq_oe), 32'd0);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin : main
        logic [31:0] a, d;
        int op;
        bit seen;
        int lows;
        rd_en = 0; wr_en = 0; address = 0; write_data = 0;
        rd_en_z = 0; wr_en_z = 0; address_z = 0; write_data_z = 0;
        z_lo = 16'($urandom); z_hi = 16'($urandom);

        #2 rst = 1'b1;
        #1;
        check("rst_read_data", read_data, 32'h0);
        check("rst_sram_addr", 32'(sram_addr), 32'h0);
        check("rst_dq_out", 32'(sram_dq_out), 32'h0);
        check("rst_oe", 32'(sram_dq_oe), 32'd0);
        check("rst_we_n", 32'(sram_we_n), 32'd1);
        check("rst_ready", 32'(ready), 32'd1);

        preload(32'd1028, 32'h5678_1234);
        preload(32'd1020, $urandom);   // below the offset: wraps to top of SRAM
        for (int k = 3; k < 16; k++) preload(32'(OFF + 4 * k), $urandom);
        @(negedge clk) rst = 1'b0;

        idle_check(5);

        // directed: store, read back, preloaded read, dual-enable store, wrap
        issue(1, 0, 32'd1024, 32'hDEAD_BEEF, 1);
        check("sram_lo_0", 32'(sram_mem[0]), 32'h0000_BEEF);
        check("sram_hi_1", 32'(sram_mem[1]), 32'h0000_DEAD);
        issue(0, 1, 32'd1024, 32'h0, 0);
        issue(0, 1, 32'd1028, 32'h0, 0);
        issue(1, 1, 32'd1032, 32'hA5A5_0F0F, 1);
        check("sram_lo_4", 32'(sram_mem[4]), 32'h0000_0F0F);
        check("sram_hi_5", 32'(sram_mem[5]), 32'h0000_A5A5);
        issue(0, 1, 32'd1020, 32'h0, 1);

        // random traffic over 16 words
        for (int n = 0; n < 40; n++) begin
            a  = 32'(OFF + 4 * $urandom_range(0, 15));
            d  = $urandom;
            op = $urandom_range(0, 2);
            issue(op != 0, op != 1, a, d, 1'($urandom_range(0, 1)));
        end

        // reset in the middle of a store
        drop();
        just_done = 1'b0;
        @(negedge clk);
        wr_en = 1'b1; address = 32'd1040; write_data = $urandom;
        repeat (2) begin @(posedge clk); #1; end
        #2 rst = 1'b1;
        #1;
        check("abort_we_n", 32'(sram_we_n), 32'd1);
        check("abort_oe", 32'(sram_dq_oe), 32'd0);
        check("abort_read_data", read_data, 32'h0);
        wr_en = 1'b0;
        #1;
        check("abort_ready", 32'(ready), 32'd1);
        ref_mem.delete(32'd1040);
        model_rd = 32'h0;
        @(posedge clk);
        @(negedge clk) rst = 1'b0;
        issue(0, 1, 32'd1028, 32'h0, 1);
        issue(0, 1, 32'd1044, 32'h0, 0);
        drop();
        repeat (2) @(negedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        // zero-wait-state instance: one read at the region base
        @(negedge clk);
        rd_en_z = 1'b1; address_z = 32'd1024;
        #1;
        check("z_req_ready", 32'(ready_z), 32'd0);
        lows = 0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge clk);
            #1;
            if (ready_z) seen = 1'b1;
            else lows++;
        end
        check("z_seen", 32'(seen), 32'd1);
        check("z_latency", 32'(lows), 32'd2);
        check("z_read_data", read_data_z, {z_hi, z_lo});
        @(negedge clk) rd_en_z = 1'b0;
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog expired");
    end

endmodule
